// File: rtl/spi_adi_reg_model.sv
// rtl/spi_adi_reg_model.sv - ADI-style 3-wire SPI slave model with a real register file
//
// Purpose: clk-oversampled SPI slave. It decodes the 16-bit ADI instruction
// (R/W, W1:W0 byte count, 13-bit address) and handles 1/2/3-byte and streaming
// transfers with an auto-decrementing address. It returns a read-only chip ID
// and has a host backdoor read port. The SDIO tristate buffer sits outside
// this module.
//
// Ports:
//   clk, rst             system clock (>= 4x SCLK), synchronous active-high reset
//   csb, sclk, sdio_i    SPI pins, asynchronous to clk
//   sdio_o, sdio_oe      SDIO read data and its output enable
//   wr_strobe            one-cycle pulse per committed byte
//   wr_addr, wr_data     address and value of the committed byte
//   host_addr            backdoor read address
//   host_rdata           register[host_addr], one-cycle registered latency
//   frame_err            sticky, set when csb rises in the middle of a byte

module spi_adi_reg_model #(
  parameter int          REG_AW      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [12:0] ID_ADDR     = 13'h001,
  parameter logic [7:0]  CHIP_ID     = 8'h73
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csb,
  input  logic              sclk,
  input  logic              sdio_i,
  output logic              sdio_o,
  output logic              sdio_oe,
  output logic              wr_strobe,
  output logic [12:0]       wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              frame_err
);

  localparam int DEPTH = 1 << REG_AW;

  typedef enum logic [2:0] {S_IDLE, S_INSTR, S_WR, S_RD, S_DONE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, sdio_sync;
  logic csb_s, sclk_s, sdio_s, csb_q, sclk_q;
  logic csb_rise, csb_fall, sclk_rise, sclk_fall;

  logic [14:0] shreg;      // instruction / write-data shifter; the 16th bit comes straight from sdio_s
  logic [4:0]  bit_cnt;
  logic [12:0] addr;
  logic [1:0]  cnt_left;   // bytes still to go after the current one (non-streaming)
  logic        stream;
  logic [7:0]  rd_byte;
  logic        oe_r;
  logic [7:0]  mem [DEPTH];

  logic [15:0] instr_word;
  logic [7:0]  wr_byte;
  logic        instr_done, byte_done, last_byte, abort_err, wr_ok;
  logic [12:0] rd_sel;
  logic [7:0]  rd_val;

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];
  assign csb_rise  = csb_s & ~csb_q;
  assign csb_fall  = ~csb_s & csb_q;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  // The registered enable lags csb by one cycle, so gate it with synced csb directly.
  assign sdio_oe = oe_r & ~csb_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (csb_rise) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (csb_fall) state_nxt = S_INSTR;
        S_INSTR: if (instr_done) state_nxt = instr_word[15] ? S_RD : S_WR;
        S_WR,
        S_RD:    if (byte_done && last_byte) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Decode of the current cycle's events and the read-side address map
  always_comb begin
    instr_word = {shreg, sdio_s};
    wr_byte    = {shreg[6:0], sdio_s};
    last_byte  = !stream && (cnt_left == 2'd0);
    instr_done = 1'b0;
    byte_done  = 1'b0;
    if (sclk_rise && !csb_rise) begin
      instr_done = (state == S_INSTR) && (bit_cnt == 5'd15);
      byte_done  = ((state == S_WR) || (state == S_RD)) && (bit_cnt == 5'd7);
    end
    abort_err = csb_rise && (bit_cnt != 5'd0) &&
                ((state == S_INSTR) || (state == S_WR) || (state == S_RD));
    // A read byte is fetched either at RD entry (instruction address) or for the next, lower address.
    rd_sel = instr_done ? instr_word[12:0] : addr - 13'd1;
    if (rd_sel == ID_ADDR)                   rd_val = CHIP_ID;
    else if ((rd_sel >> REG_AW) != 13'd0)    rd_val = 8'h00;
    else                                     rd_val = mem[rd_sel[REG_AW-1:0]];
    wr_ok = (addr != ID_ADDR) && ((addr >> REG_AW) == 13'd0);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_sync   <= '0;
      sclk_sync  <= '0;
      sdio_sync  <= '0;
      csb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      cnt_left   <= '0;
      stream     <= 1'b0;
      rd_byte    <= '0;
      oe_r       <= 1'b0;
      sdio_o     <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      host_rdata <= '0;
      frame_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      csb_sync   <= {csb_sync[SYNC_STAGES-2:0], csb};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdio_sync  <= {sdio_sync[SYNC_STAGES-2:0], sdio_i};
      csb_q      <= csb_s;
      sclk_q     <= sclk_s;
      wr_strobe  <= 1'b0;
      host_rdata <= mem[host_addr];
      if (abort_err) frame_err <= 1'b1;

      if (csb_rise) begin
        oe_r    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (csb_fall) begin
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          S_INSTR: begin
            if (sclk_rise) begin
              shreg   <= instr_word[14:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (instr_done) begin
                addr     <= instr_word[12:0];
                cnt_left <= instr_word[14:13];
                stream   <= &instr_word[14:13];
                bit_cnt  <= '0;
                rd_byte  <= rd_val;
              end
            end
          end
          S_WR: begin
            if (sclk_rise) begin
              shreg   <= {shreg[13:0], sdio_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (byte_done) begin
                bit_cnt   <= '0;
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= wr_byte;
                if (wr_ok) mem[addr[REG_AW-1:0]] <= wr_byte;
                addr <= addr - 13'd1;
                if (!stream && !last_byte) cnt_left <= cnt_left - 2'd1;
              end
            end
          end
          S_RD: begin
            if (sclk_fall) begin
              oe_r   <= 1'b1;
              sdio_o <= rd_byte[3'd7 - bit_cnt[2:0]];
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (byte_done) begin
                bit_cnt <= '0;
                addr    <= addr - 13'd1;
                rd_byte <= rd_val;
                if (last_byte)    oe_r     <= 1'b0;
                else if (!stream) cnt_left <= cnt_left - 2'd1;
              end
            end
          end
          default: oe_r <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_adi_reg_model.sv
// tb/tb_spi_adi_reg_model.sv - scoreboard bench for spi_adi_reg_model
module tb_spi_adi_reg_model;

  localparam int SYNC = 2;
  localparam int H    = 4;   // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        rst, csb, sclk, sdio_i;
  logic        sdio_o, sdio_oe, wr_strobe, frame_err;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data, host_rdata;
  logic [7:0]  host_addr;

  spi_adi_reg_model #(
    .REG_AW(8), .SYNC_STAGES(SYNC), .ID_ADDR(13'h001), .CHIP_ID(8'h73)
  ) dut (
    .clk(clk), .rst(rst), .csb(csb), .sclk(sclk), .sdio_i(sdio_i),
    .sdio_o(sdio_o), .sdio_oe(sdio_oe), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .host_addr(host_addr),
    .host_rdata(host_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [20:0] exp_wr[$];   // {addr, data}
  logic [7:0]  exp_rd[$];
  logic [7:0]  wq[$];       // data for the next write; random when empty
  logic [7:0]  ref_mem [256];
  int          oe_total = 0;
  int          rd_nbits = 0;
  logic [7:0]  rd_shift = 8'h00;
  logic [20:0] wr_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, got);
  endtask

  // Reference model: plain address map
  function automatic logic [7:0] model_read(input logic [12:0] a);
    if (a == 13'h001) return 8'h73;
    if (a > 13'd255)  return 8'h00;
    return ref_mem[a[7:0]];
  endfunction

  function automatic void model_write(input logic [12:0] a, input logic [7:0] d);
    if (a <= 13'd255 && a != 13'h001) ref_mem[a[7:0]] = d;
  endfunction

  // Write-commit monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wr_strobe === 1'b1) begin
        if (exp_wr.size() == 0) fail_now("wr_strobe_unexpected", {19'd0, wr_addr});
        else begin
          wr_e = exp_wr.pop_front();
          check("wr_addr", {19'd0, wr_addr}, {19'd0, wr_e[20:8]});
          check("wr_data", {24'd0, wr_data}, {24'd0, wr_e[7:0]});
        end
      end
    end
  end

  // Read-data monitor: master samples SDIO on SCLK rise
  initial begin
    forever begin
      @(posedge sclk or posedge csb);
      if (csb) rd_nbits = 0;
      else if (sdio_oe === 1'b1) begin
        oe_total++;
        rd_shift = {rd_shift[6:0], sdio_o};
        rd_nbits++;
        if (rd_nbits == 8) begin
          rd_nbits = 0;
          if (exp_rd.size() == 0) fail_now("rd_byte_unexpected", {24'd0, rd_shift});
          else check("rd_byte", {24'd0, rd_shift}, {24'd0, exp_rd.pop_front()});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0; sdio_i = v[i]; clk_wait(H);
      sclk = 1'b1; clk_wait(H);
    end
  endtask

  task automatic clock_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; sdio_i = 1'b0; clk_wait(H);
      sclk = 1'b1; clk_wait(H);
    end
  endtask

  task automatic frame_begin();
    sclk = 1'b0; csb = 1'b0; clk_wait(H);
  endtask

  task automatic frame_end();
    sclk = 1'b0; clk_wait(H); csb = 1'b1; clk_wait(3 * H);
  endtask

  task automatic spi_write(input logic [12:0] a, input logic [1:0] w, input int nbytes);
    logic [7:0]  d;
    logic [12:0] ad;
    frame_begin();
    send_bits({1'b0, w, a}, 16);
    for (int i = 0; i < nbytes; i++) begin
      d  = (wq.size() != 0) ? wq.pop_front() : 8'($urandom);
      ad = 13'(a - 13'(i));
      exp_wr.push_back({ad, d});
      model_write(ad, d);
      send_bits({8'h00, d}, 8);
    end
    frame_end();
  endtask

  task automatic spi_read(input logic [12:0] a, input logic [1:0] w, input int nbits);
    int nb, exp_oe, start;
    nb = nbits / 8;
    exp_oe = nbits;
    if (w != 2'd3) begin
      if (nb > int'(w) + 1) nb = int'(w) + 1;
      if (exp_oe > 8 * (int'(w) + 1)) exp_oe = 8 * (int'(w) + 1);
    end
    for (int i = 0; i < nb; i++) exp_rd.push_back(model_read(13'(a - 13'(i))));
    start = oe_total;
    frame_begin();
    send_bits({1'b1, w, a}, 16);
    clock_bits(nbits);
    frame_end();
    check("rd_oe_bits", oe_total - start, exp_oe);
  endtask

  task automatic host_check(input logic [7:0] a, input logic [7:0] exp);
    host_addr = a;
    clk_wait(1);
    check("host_rdata", {24'd0, host_rdata}, {24'd0, exp});
  endtask

  function automatic logic [12:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 13'($urandom_range(0, 3));
      1:       return 13'($urandom_range(8189, 8191));
      2:       return 13'($urandom_range(250, 260));
      default: return 13'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [12:0] ra;
    logic [1:0]  rw;
    int          rn;
    logic [7:0]  ha;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; csb = 1'b1; sclk = 1'b0; sdio_i = 1'b0; host_addr = 8'h00;
    clk_wait(4);
    check("reset_outputs", {13'd0, sdio_o, sdio_oe, wr_strobe, frame_err, wr_data, host_rdata},
          32'd0);
    check("reset_wr_addr", {19'd0, wr_addr}, 32'd0);
    rst = 1'b0;
    clk_wait(3 * H);

    // 1-byte write
    wq.push_back(8'hA5);
    spi_write(13'h010, 2'd0, 1);
    host_check(8'h10, 8'hA5);
    check("frame_err_clean", {31'd0, frame_err}, 32'd0);

    // 3-byte write then read back
    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    spi_write(13'h020, 2'd2, 3);
    host_check(8'h20, 8'h11);
    host_check(8'h1F, 8'h22);
    host_check(8'h1E, 8'h33);
    spi_read(13'h020, 2'd2, 24);

    // Streaming read across ID, 0 and the 13-bit wrap; ID is not writable
    spi_read(13'h001, 2'd3, 40);
    wq.push_back(8'h5A);
    spi_write(13'h001, 2'd0, 1);
    spi_read(13'h001, 2'd0, 8);
    host_check(8'h01, 8'h00);

    // Abort mid-byte
    frame_begin();
    send_bits(16'h0040, 16);
    send_bits(16'h000A, 4);
    sclk = 1'b0; clk_wait(H);
    csb = 1'b1;
    clk_wait(SYNC + 2);
    check("abort_frame_err", {31'd0, frame_err}, 32'd1);
    check("abort_oe", {31'd0, sdio_oe}, 32'd0);
    clk_wait(3 * H);
    wq.push_back(8'h3C);
    spi_write(13'h040, 2'd0, 1);
    host_check(8'h40, 8'h3C);

    // 1-byte read with extra clocks after DONE
    spi_read(13'h010, 2'd0, 24);

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      ra = rand_addr();
      rw = 2'($urandom_range(0, 3));
      rn = (rw == 2'd3) ? $urandom_range(1, 4) : int'(rw) + 1;
      if ($urandom_range(0, 1) == 1) spi_write(ra, rw, rn);
      else spi_read(ra, rw, 8 * rn);
    end
    for (int k = 0; k < 8; k++) begin
      ha = 8'($urandom_range(0, 255));
      host_check(ha, ref_mem[ha]);
    end
    check("frame_err_sticky", {31'd0, frame_err}, 32'd1);

    // Reset in the middle of a read
    frame_begin();
    send_bits(16'h8020, 16);
    clock_bits(4);
    check("rd_oe_before_rst", {31'd0, sdio_oe}, 32'd1);
    rst = 1'b1;
    clk_wait(1);
    check("midrst_outputs", {13'd0, sdio_o, sdio_oe, wr_strobe, frame_err, wr_data, host_rdata},
          32'd0);
    check("midrst_wr_addr", {19'd0, wr_addr}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    clock_bits(4);
    frame_end();
    host_check(8'h20, 8'h00);
    host_check(8'h10, 8'h00);
    spi_write(13'h025, 2'd1, 2);
    spi_read(13'h025, 2'd1, 16);
    host_check(8'h25, ref_mem[8'h25]);
    host_check(8'h24, ref_mem[8'h24]);
    check("frame_err_after_rst", {31'd0, frame_err}, 32'd0);

    clk_wait(4 * H);
    check("exp_wr_drained", exp_wr.size(), 32'd0);
    check("exp_rd_drained", exp_rd.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
